// File: rtl/mc_exe_ctrl_pkg.sv
// rtl/mc_exe_ctrl_pkg.sv - shared types and configuration defaults for the multi-cycle execution controller
//
// Purpose : register-file and exception-code types, result width, and the
//           per-unit latency / depth defaults used when instantiating
//           mc_exe_ctrl for the divider, FPU and multiplier.
// Ports   : none (package).
package mc_exe_ctrl_pkg;

  localparam int DataWidth          = 32;

  // Datapath latency defaults per execution unit.
  localparam int DivLatency         = 16;
  localparam int FpuLatency         = 4;
  localparam int MulLatency         = 3;

  // Controller defaults: in-flight plus buffered capacity, issue mode.
  localparam int McExeCtrlDepth     = 4;
  localparam int McExeCtrlPipelined = 1;

  typedef logic [4:0] RegFile_t;
  typedef logic [3:0] ExpCode_t;

  typedef enum logic [1:0] {
    EXE_CMD_DIV = 2'd0,
    EXE_CMD_FPU = 2'd1,
    EXE_CMD_MUL = 2'd2
  } exe_cmd_e;

endpackage

// File: rtl/mc_exe_rbuf.sv
// rtl/mc_exe_rbuf.sv - DEPTH-entry result FIFO for the multi-cycle execution controller
//
// Purpose : holds completed datapath results until writeback is granted.
// Ports   : clk, reset_ (async active-low), clr_ (sync active-low empty),
//           push/push_data (enqueue), pop (dequeue head),
//           head (oldest entry), count (occupancy), empty.
// DEPTH must be a power of two so pointers wrap naturally modulo DEPTH.
module mc_exe_rbuf #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset_,
  input  logic                     clr_,
  input  logic                     push,
  input  logic [W-1:0]             push_data,
  input  logic                     pop,
  output logic [W-1:0]             head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty
);

  localparam int PW = $clog2(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [PW-1:0] r_wp;
  logic [PW-1:0] r_rp;
  logic [PW:0]   r_cnt;

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else if (!clr_) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      if (push) r_wp <= r_wp + 1'b1;
      if (pop)  r_rp <= r_rp + 1'b1;
      case ({push, pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) r_mem[r_wp] <= push_data;
  end

  assign head  = r_mem[r_rp];
  assign count = r_cnt;
  assign empty = (r_cnt == '0);

  a_no_overflow: assert property (@(posedge clk) disable iff (!reset_)
    !(push && !pop && (r_cnt == (PW+1)'(DEPTH))));

  a_no_underflow: assert property (@(posedge clk) disable iff (!reset_)
    !(pop && (r_cnt == '0)));

endmodule

// File: rtl/mc_exe_ctrl.sv
// rtl/mc_exe_ctrl.sv - issue/latency tracking and writeback arbitration for fixed-latency execution units
//
// Purpose : accepts issues, launches the external datapath, tracks each op
//           through a LATENCY-stage valid/rd shift register, captures results
//           (bypass or result FIFO) and requests writeback with a one-cycle
//           early destination prediction.
// Ports   : clk, reset_ (async active-low), flush_ (kill all ops),
//           issue_/rd (issue request), busy_/exe_start_ (issue handshake,
//           datapath launch), res/res_exp_/res_exp_code (datapath result),
//           wb_req_/pred_wb_rd/wb_ack_ (writeback arbitration),
//           wb_e_/wb_rd/wb_data/wb_exp_/wb_exp_code (registered writeback),
//           stall_cnt (writeback stall counter).
// Option  : MC_EXE_CTRL_STALL_CNT_EN enables the saturating stall counter;
//           without it stall_cnt is tied to zero.
module mc_exe_ctrl
  import mc_exe_ctrl_pkg::*;
#(
  parameter int DATA      = DataWidth,
  parameter int LATENCY   = 8,
  parameter int DEPTH     = McExeCtrlDepth,
  parameter int PIPELINED = McExeCtrlPipelined
) (
  input  logic            clk,
  input  logic            reset_,
  input  logic            flush_,
  input  logic            issue_,
  input  RegFile_t        rd,
  output logic            busy_,
  output logic            exe_start_,
  input  logic [DATA-1:0] res,
  input  logic            res_exp_,
  input  ExpCode_t        res_exp_code,
  output logic            wb_req_,
  output RegFile_t        pred_wb_rd,
  input  logic            wb_ack_,
  output logic            wb_e_,
  output RegFile_t        wb_rd,
  output logic [DATA-1:0] wb_data,
  output logic            wb_exp_,
  output ExpCode_t        wb_exp_code,
  output logic [31:0]     stall_cnt
);

  localparam int EW = $bits(RegFile_t) + 1 + $bits(ExpCode_t) + DATA;
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int OW = $clog2(LATENCY + DEPTH + 1);

  // Stage i holds the op issued i+1 cycles ago; the last stage lines up
  // with the cycle in which the datapath presents its result.
  logic [LATENCY-1:0] r_stg_vld;
  RegFile_t           r_stg_rd [LATENCY];

  logic          w_accept;
  logic          w_iter_hold;
  logic [OW-1:0] w_occ;
  logic          w_arr;
  logic [EW-1:0] w_arr_entry;
  logic [EW-1:0] w_buf_head;
  logic [CW-1:0] w_buf_cnt;
  logic          w_buf_empty;
  logic [EW-1:0] w_src_entry;
  logic          w_src_vld;
  RegFile_t      w_src_rd;
  logic          w_src_exp_;
  ExpCode_t      w_src_code;
  logic [DATA-1:0] w_src_data;
  logic          w_consume;
  logic          w_push;
  logic          w_pop;

  // Occupancy counts in-flight stages and buffered results together so the
  // buffer can never be asked to hold more than DEPTH entries.
  always_comb begin
    w_occ = OW'(w_buf_cnt);
    for (int i = 0; i < LATENCY; i++) begin
      w_occ = w_occ + OW'(r_stg_vld[i]);
    end
  end

  assign w_iter_hold = (PIPELINED == 0) && (|r_stg_vld);
  // Only registered state (and reset) feeds busy_, keeping issue_ off this path.
  assign busy_       = reset_ && !((w_occ >= OW'(DEPTH)) || w_iter_hold);
  assign w_accept    = !issue_ && busy_ && flush_;
  assign exe_start_  = !w_accept;

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      r_stg_vld <= '0;
    end else if (!flush_) begin
      r_stg_vld <= '0;
    end else begin
      r_stg_vld[0] <= w_accept;
      for (int i = 1; i < LATENCY; i++) begin
        r_stg_vld[i] <= r_stg_vld[i-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    r_stg_rd[0] <= rd;
    for (int i = 1; i < LATENCY; i++) begin
      r_stg_rd[i] <= r_stg_rd[i-1];
    end
  end

  assign w_arr       = r_stg_vld[LATENCY-1];
  assign w_arr_entry = {r_stg_rd[LATENCY-1], res_exp_, res_exp_code, res};

  // Older buffered results always go first; the arriving result may only
  // bypass the buffer when the buffer is empty, which preserves FIFO order.
  assign w_src_vld   = !w_buf_empty || w_arr;
  assign w_src_entry = w_buf_empty ? w_arr_entry : w_buf_head;
  assign {w_src_rd, w_src_exp_, w_src_code, w_src_data} = w_src_entry;

  assign wb_req_    = !(w_src_vld && flush_);
  assign pred_wb_rd = w_src_rd;
  assign w_consume  = !wb_req_ && !wb_ack_;
  assign w_pop      = w_consume && !w_buf_empty;
  assign w_push     = w_arr && flush_ && !(w_consume && w_buf_empty);

  mc_exe_rbuf #(
    .W     (EW),
    .DEPTH (DEPTH)
  ) u_rbuf (
    .clk       (clk),
    .reset_    (reset_),
    .clr_      (flush_),
    .push      (w_push),
    .push_data (w_arr_entry),
    .pop       (w_pop),
    .head      (w_buf_head),
    .count     (w_buf_cnt),
    .empty     (w_buf_empty)
  );

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      wb_e_       <= 1'b1;
      wb_exp_     <= 1'b1;
      wb_rd       <= '0;
      wb_data     <= '0;
      wb_exp_code <= '0;
    end else begin
      wb_e_ <= !w_consume;
      if (w_consume) begin
        wb_rd       <= w_src_rd;
        wb_data     <= w_src_data;
        wb_exp_     <= w_src_exp_;
        wb_exp_code <= w_src_code;
      end
    end
  end

`ifdef MC_EXE_CTRL_STALL_CNT_EN
  logic [31:0] r_stall_cnt;

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      r_stall_cnt <= '0;
    end else if (!flush_) begin
      r_stall_cnt <= '0;
    end else if (!wb_req_ && wb_ack_ && (r_stall_cnt != '1)) begin
      r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

  assign stall_cnt = r_stall_cnt;
`else
  assign stall_cnt = '0;
`endif

  a_no_dropped_issue: assert property (@(posedge clk) disable iff (!reset_)
    !(!issue_ && !busy_ && flush_));

endmodule

// File: tb/tb_mc_exe_ctrl.sv
// tb/tb_mc_exe_ctrl.sv - directed self-checking bench for mc_exe_ctrl
module tb_mc_exe_ctrl;
  import mc_exe_ctrl_pkg::*;

`ifdef MC_EXE_CTRL_STALL_CNT_EN
  localparam bit STALL_EN = 1'b1;
`else
  localparam bit STALL_EN = 1'b0;
`endif

  logic        clk;
  logic        reset_;
  logic        flush_;
  logic        wb_ack_;
  logic [31:0] res;
  logic        res_exp_;
  ExpCode_t    res_exp_code;

  // Pipelined instance: LATENCY=4, DEPTH=4
  logic        p_issue_;
  RegFile_t    p_rd;
  logic        p_busy_, p_exe_start_, p_wb_req_, p_wb_e_, p_wb_exp_;
  RegFile_t    p_pred, p_wb_rd;
  logic [31:0] p_wb_data, p_stall;
  ExpCode_t    p_wb_code;

  // Iterative instance: LATENCY=8, DEPTH=4
  logic        q_issue_;
  RegFile_t    q_rd;
  logic        q_busy_, q_exe_start_, q_wb_req_, q_wb_e_, q_wb_exp_;
  RegFile_t    q_pred, q_wb_rd;
  logic [31:0] q_wb_data, q_stall;
  ExpCode_t    q_wb_code;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  mc_exe_ctrl #(.DATA(32), .LATENCY(4), .DEPTH(4), .PIPELINED(1)) u_dut (
    .clk(clk), .reset_(reset_), .flush_(flush_), .issue_(p_issue_), .rd(p_rd),
    .busy_(p_busy_), .exe_start_(p_exe_start_), .res(res), .res_exp_(res_exp_),
    .res_exp_code(res_exp_code), .wb_req_(p_wb_req_), .pred_wb_rd(p_pred),
    .wb_ack_(wb_ack_), .wb_e_(p_wb_e_), .wb_rd(p_wb_rd), .wb_data(p_wb_data),
    .wb_exp_(p_wb_exp_), .wb_exp_code(p_wb_code), .stall_cnt(p_stall)
  );

  mc_exe_ctrl #(.DATA(32), .LATENCY(8), .DEPTH(4), .PIPELINED(0)) u_dut_iter (
    .clk(clk), .reset_(reset_), .flush_(flush_), .issue_(q_issue_), .rd(q_rd),
    .busy_(q_busy_), .exe_start_(q_exe_start_), .res(res), .res_exp_(res_exp_),
    .res_exp_code(res_exp_code), .wb_req_(q_wb_req_), .pred_wb_rd(q_pred),
    .wb_ack_(wb_ack_), .wb_e_(q_wb_e_), .wb_rd(q_wb_rd), .wb_data(q_wb_data),
    .wb_exp_(q_wb_exp_), .wb_exp_code(q_wb_code), .stall_cnt(q_stall)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Advance to just after the next rising edge; res carries a per-cycle tag
  // so each result's data identifies the cycle it arrived in.
  task automatic next_cycle();
    @(posedge clk);
    #1;
    cyc = cyc + 1;
    res = 32'hA500_0000 | cyc;
  endtask

  task automatic test_reset();
    reset_ = 1'b0; flush_ = 1'b1; wb_ack_ = 1'b1; res_exp_ = 1'b1; res_exp_code = '0;
    p_issue_ = 1'b1; p_rd = '0; q_issue_ = 1'b1; q_rd = '0; res = '0;
    repeat (3) next_cycle();
    @(negedge clk);
    n_cmp++; if (p_wb_e_ !== 1'b1) begin n_err++; $display("FAIL reset_wb_e got %b want 1", p_wb_e_); end
    n_cmp++; if (p_wb_exp_ !== 1'b1) begin n_err++; $display("FAIL reset_wb_exp got %b want 1", p_wb_exp_); end
    n_cmp++; if (p_wb_rd !== 5'd0) begin n_err++; $display("FAIL reset_wb_rd got %0d want 0", p_wb_rd); end
    n_cmp++; if (p_wb_data !== 32'd0) begin n_err++; $display("FAIL reset_wb_data got %h want 0", p_wb_data); end
    n_cmp++; if (p_wb_code !== 4'd0) begin n_err++; $display("FAIL reset_wb_code got %h want 0", p_wb_code); end
    n_cmp++; if (p_wb_req_ !== 1'b1) begin n_err++; $display("FAIL reset_wb_req got %b want 1", p_wb_req_); end
    n_cmp++; if (p_busy_ !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b want 0", p_busy_); end
    n_cmp++; if (q_busy_ !== 1'b0) begin n_err++; $display("FAIL reset_busy_iter got %b want 0", q_busy_); end
    n_cmp++; if (p_stall !== 32'd0) begin n_err++; $display("FAIL reset_stall got %0d want 0", p_stall); end
    next_cycle();
    reset_ = 1'b1;
    @(negedge clk);
    n_cmp++; if (p_busy_ !== 1'b1) begin n_err++; $display("FAIL post_reset_busy got %b want 1", p_busy_); end
    n_cmp++; if (p_exe_start_ !== 1'b1) begin n_err++; $display("FAIL post_reset_exe_start got %b want 1", p_exe_start_); end
  endtask

  task automatic test_single_op();
    int c0;
    logic exp_req, exp_e;
    next_cycle();
    c0 = cyc; p_issue_ = 1'b0; p_rd = 5'd5; wb_ack_ = 1'b0;
    @(negedge clk);
    n_cmp++; if (p_exe_start_ !== 1'b0) begin n_err++; $display("FAIL single_exe_start got %b want 0", p_exe_start_); end
    for (int k = 1; k <= 6; k++) begin
      next_cycle();
      p_issue_ = 1'b1;
      @(negedge clk);
      exp_req = (k == 4) ? 1'b0 : 1'b1;
      exp_e   = (k == 5) ? 1'b0 : 1'b1;
      n_cmp++; if (p_wb_req_ !== exp_req) begin n_err++; $display("FAIL single_wb_req k=%0d got %b want %b", k, p_wb_req_, exp_req); end
      n_cmp++; if (p_wb_e_ !== exp_e) begin n_err++; $display("FAIL single_wb_e k=%0d got %b want %b", k, p_wb_e_, exp_e); end
      if (k == 4) begin
        n_cmp++; if (p_pred !== 5'd5) begin n_err++; $display("FAIL single_pred got %0d want 5", p_pred); end
      end
      if (k == 5) begin
        n_cmp++; if (p_wb_rd !== 5'd5) begin n_err++; $display("FAIL single_wb_rd got %0d want 5", p_wb_rd); end
        n_cmp++; if (p_wb_data !== (32'hA500_0000 | (c0 + 4))) begin n_err++;
          $display("FAIL single_wb_data got %h want %h", p_wb_data, 32'hA500_0000 | (c0 + 4)); end
      end
    end
  endtask

  task automatic test_back_to_back();
    int b0;
    logic exp_busy;
    b0 = cyc + 1;
    for (int k = 0; k <= 8; k++) begin
      next_cycle();
      wb_ack_ = 1'b1;
      if (k < 4) begin p_issue_ = 1'b0; p_rd = RegFile_t'(k + 1); end
      else p_issue_ = 1'b1;
      @(negedge clk);
      if (k < 4) begin
        n_cmp++; if (p_exe_start_ !== 1'b0) begin n_err++; $display("FAIL b2b_exe_start k=%0d got %b want 0", k, p_exe_start_); end
      end else begin
        n_cmp++; if (p_busy_ !== 1'b0) begin n_err++; $display("FAIL b2b_busy_full k=%0d got %b want 0", k, p_busy_); end
        n_cmp++; if (p_wb_req_ !== 1'b0) begin n_err++; $display("FAIL b2b_req_held k=%0d got %b want 0", k, p_wb_req_); end
        n_cmp++; if (p_pred !== 5'd1) begin n_err++; $display("FAIL b2b_pred_head k=%0d got %0d want 1", k, p_pred); end
      end
    end
    for (int j = 0; j <= 4; j++) begin
      next_cycle();
      wb_ack_ = 1'b0;
      @(negedge clk);
      exp_busy = (j == 0) ? 1'b0 : 1'b1;
      n_cmp++; if (p_busy_ !== exp_busy) begin n_err++; $display("FAIL b2b_busy_drain j=%0d got %b want %b", j, p_busy_, exp_busy); end
      if (j < 4) begin
        n_cmp++; if (p_pred !== RegFile_t'(j + 1)) begin n_err++; $display("FAIL b2b_pred j=%0d got %0d want %0d", j, p_pred, j + 1); end
      end else begin
        n_cmp++; if (p_wb_req_ !== 1'b1) begin n_err++; $display("FAIL b2b_req_empty got %b want 1", p_wb_req_); end
      end
      if (j > 0) begin
        n_cmp++; if (p_wb_e_ !== 1'b0) begin n_err++; $display("FAIL b2b_wb_e j=%0d got %b want 0", j, p_wb_e_); end
        n_cmp++; if (p_wb_rd !== RegFile_t'(j)) begin n_err++; $display("FAIL b2b_wb_rd j=%0d got %0d want %0d", j, p_wb_rd, j); end
        n_cmp++; if (p_wb_data !== (32'hA500_0000 | (b0 + 3 + j))) begin n_err++;
          $display("FAIL b2b_wb_data j=%0d got %h want %h", j, p_wb_data, 32'hA500_0000 | (b0 + 3 + j)); end
      end
    end
    next_cycle();
    wb_ack_ = 1'b1;
    @(negedge clk);
    n_cmp++; if (p_wb_e_ !== 1'b1) begin n_err++; $display("FAIL b2b_wb_e_end got %b want 1", p_wb_e_); end
  endtask

  task automatic test_iterative();
    int t0;
    logic exp_busy;
    next_cycle();
    t0 = cyc; q_issue_ = 1'b0; q_rd = 5'd3; wb_ack_ = 1'b0;
    @(negedge clk);
    n_cmp++; if (q_exe_start_ !== 1'b0) begin n_err++; $display("FAIL iter_exe_start0 got %b want 0", q_exe_start_); end
    for (int k = 1; k <= 18; k++) begin
      next_cycle();
      q_issue_ = 1'b1;
      if (k == 9) begin q_issue_ = 1'b0; q_rd = 5'd4; end
      @(negedge clk);
      if (k <= 9) begin
        exp_busy = (k <= 8) ? 1'b0 : 1'b1;
        n_cmp++; if (q_busy_ !== exp_busy) begin n_err++; $display("FAIL iter_busy k=%0d got %b want %b", k, q_busy_, exp_busy); end
      end
      if (k == 9) begin
        n_cmp++; if (q_exe_start_ !== 1'b0) begin n_err++; $display("FAIL iter_exe_start9 got %b want 0", q_exe_start_); end
        n_cmp++; if (q_wb_e_ !== 1'b0) begin n_err++; $display("FAIL iter_wb_e_first got %b want 0", q_wb_e_); end
        n_cmp++; if (q_wb_rd !== 5'd3) begin n_err++; $display("FAIL iter_wb_rd_first got %0d want 3", q_wb_rd); end
      end
      if (k == 18) begin
        n_cmp++; if (q_wb_e_ !== 1'b0) begin n_err++; $display("FAIL iter_wb_e_second got %b want 0", q_wb_e_); end
        n_cmp++; if (q_wb_rd !== 5'd4) begin n_err++; $display("FAIL iter_wb_rd_second got %0d want 4", q_wb_rd); end
        n_cmp++; if (q_wb_data !== (32'hA500_0000 | (t0 + 17))) begin n_err++;
          $display("FAIL iter_wb_data got %h want %h", q_wb_data, 32'hA500_0000 | (t0 + 17)); end
      end
    end
  endtask

  task automatic test_flush();
    for (int k = 0; k <= 4; k++) begin
      next_cycle();
      wb_ack_ = 1'b1;
      if (k < 3) begin p_issue_ = 1'b0; p_rd = RegFile_t'(7 + k); end
      else p_issue_ = 1'b1;
      @(negedge clk);
      if (k == 4) begin
        n_cmp++; if (p_pred !== 5'd7) begin n_err++; $display("FAIL flush_pre_pred got %0d want 7", p_pred); end
      end
    end
    next_cycle();
    flush_ = 1'b0; p_issue_ = 1'b0; p_rd = 5'd10; wb_ack_ = 1'b0;
    @(negedge clk);
    n_cmp++; if (p_exe_start_ !== 1'b1) begin n_err++; $display("FAIL flush_exe_start got %b want 1", p_exe_start_); end
    n_cmp++; if (p_wb_req_ !== 1'b1) begin n_err++; $display("FAIL flush_wb_req got %b want 1", p_wb_req_); end
    for (int k = 1; k <= 5; k++) begin
      next_cycle();
      flush_ = 1'b1; p_issue_ = 1'b1; wb_ack_ = 1'b0;
      @(negedge clk);
      n_cmp++; if (p_wb_e_ !== 1'b1) begin n_err++; $display("FAIL flush_wb_e k=%0d got %b want 1", k, p_wb_e_); end
      n_cmp++; if (p_wb_req_ !== 1'b1) begin n_err++; $display("FAIL flush_wb_req_after k=%0d got %b want 1", k, p_wb_req_); end
      if (k == 1) begin
        n_cmp++; if (p_busy_ !== 1'b1) begin n_err++; $display("FAIL flush_busy got %b want 1", p_busy_); end
      end
    end
  endtask

  task automatic test_exception();
    next_cycle();
    p_issue_ = 1'b0; p_rd = 5'd12; wb_ack_ = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      next_cycle();
      p_issue_ = 1'b1;
      if (k == 4) begin res_exp_ = 1'b0; res_exp_code = 4'hB; end
      else begin res_exp_ = 1'b1; res_exp_code = 4'h0; end
      @(negedge clk);
      if (k == 4) begin
        n_cmp++; if (p_pred !== 5'd12) begin n_err++; $display("FAIL exc_pred got %0d want 12", p_pred); end
      end
      if (k == 5) begin
        n_cmp++; if (p_wb_e_ !== 1'b0) begin n_err++; $display("FAIL exc_wb_e got %b want 0", p_wb_e_); end
        n_cmp++; if (p_wb_exp_ !== 1'b0) begin n_err++; $display("FAIL exc_wb_exp got %b want 0", p_wb_exp_); end
        n_cmp++; if (p_wb_code !== 4'hB) begin n_err++; $display("FAIL exc_wb_code got %h want b", p_wb_code); end
        n_cmp++; if (p_wb_rd !== 5'd12) begin n_err++; $display("FAIL exc_wb_rd got %0d want 12", p_wb_rd); end
        n_cmp++; if (p_wb_req_ !== 1'b1) begin n_err++; $display("FAIL exc_buffer_empty got %b want 1", p_wb_req_); end
      end
      if (k == 6) begin
        n_cmp++; if (p_wb_e_ !== 1'b1) begin n_err++; $display("FAIL exc_wb_e_once got %b want 1", p_wb_e_); end
      end
    end
  endtask

  task automatic test_stall_cnt();
    logic [31:0] exp_cnt;
    next_cycle();
    flush_ = 1'b0; p_issue_ = 1'b1; wb_ack_ = 1'b1;
    next_cycle();
    flush_ = 1'b1; p_issue_ = 1'b0; p_rd = 5'd2;
    @(negedge clk);
    n_cmp++; if (p_stall !== 32'd0) begin n_err++; $display("FAIL stall_start got %0d want 0", p_stall); end
    for (int k = 1; k <= 12; k++) begin
      next_cycle();
      p_issue_ = 1'b1;
      flush_ = (k == 11) ? 1'b0 : 1'b1;
      @(negedge clk);
      if (k == 10) begin
        n_cmp++; if (p_wb_req_ !== 1'b0) begin n_err++; $display("FAIL stall_req_held got %b want 0", p_wb_req_); end
      end
      if (k == 11) begin
        exp_cnt = STALL_EN ? 32'd7 : 32'd0;
        n_cmp++; if (p_stall !== exp_cnt) begin n_err++; $display("FAIL stall_count got %0d want %0d", p_stall, exp_cnt); end
      end
      if (k == 12) begin
        n_cmp++; if (p_stall !== 32'd0) begin n_err++; $display("FAIL stall_flush got %0d want 0", p_stall); end
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_op();
    test_back_to_back();
    test_iterative();
    test_flush();
    test_exception();
    test_stall_cnt();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mc_exe_ctrl.md
Name: mc_exe_ctrl

Overview:
- Parametrised control block for fixed-latency multi-cycle execution units (divider, FPU, multiplier).
- Tracks in-flight operations, either pipelined or iterative, and launches them into an external datapath.
- Captures datapath results into a result buffer, then arbitrates writeback with wb_req_/wb_ack_, giving a one-cycle-early destination prediction.
- Sits between the issue stage and the shared writeback arbiter.

Parameters:
- DATA, `DataWidth, result width.
- LATENCY, 8, datapath latency in cycles from exe_start_ to res valid; LATENCY >= 1.
- DEPTH, 4, maximum in-flight plus buffered operations; result buffer entries.
- PIPELINED, 1, 1 = new op every cycle; 0 = iterative, one op in datapath at a time.

Ports:
- clk  in  1  clock
- reset_  in  1  async active-low reset
- flush_  in  1  active-low; kill all in-flight and buffered ops
- issue_  in  1  active-low issue request
- rd  in  RegFile_t  destination of issued op
- busy_  out  1  active-low; issue not accepted this cycle
- exe_start_  out  1  active-low; launch datapath (combinational from issue_ & accept)
- res  in  DATA  datapath result
- res_exp_  in  1  datapath exception flag
- res_exp_code  in  ExpCode_t  datapath exception code
- wb_req_  out  1  writeback request
- pred_wb_rd  out  RegFile_t  destination written on next wb_e_ if acked now
- wb_ack_  in  1  writeback grant
- wb_e_  out  1  writeback valid (registered)
- wb_rd  out  RegFile_t  writeback destination
- wb_data  out  DATA  writeback data
- wb_exp_  out  1  writeback exception
- wb_exp_code  out  ExpCode_t  writeback exception code
- stall_cnt  out  32  writeback stall counter (see optional feature)

Behaviour:
- Reset: all valid bits cleared, buffer empty, wb_e_=1, wb_exp_=1, wb_rd/wb_data/wb_exp_code=0, wb_req_=1, busy_=0, stall_cnt=0.
- Tracking: shift register of LATENCY stages {valid, rd}. Issue accepted at cycle t0 enters stage 1 at t0+1. Stage LATENCY is valid at t0+LATENCY, which is the cycle res is sampled.
- occ = count of valid stages + buffer count.
- busy_=0 when occ >= DEPTH, or (PIPELINED==0 and any stage valid). busy_ derives from registered state only.
- Accept = !issue_ & busy_ & flush_. exe_start_ = !accept.
- An issue while busy_=0 is dropped; a simulation assertion fires.
- Result source, in cycle t: buffer head if buffer nonempty, else the arriving result (stage LATENCY valid), else none.
- wb_req_=0 iff a source exists and flush_=1. pred_wb_rd = source rd.
- Ack: wb_ack_=0 and wb_req_=0 in cycle t. At end of t, wb_* registers load the source, and the source is consumed (buffer pop, or arriving result bypassed and not pushed). wb_e_=0 in t+1 for exactly one cycle.
- Ack without request is ignored.
- Minimum issue-to-wb_e_ latency is LATENCY+1.
- An arriving result not consumed is pushed to the buffer. Pop plus push in the same cycle is legal. Order is strictly FIFO; results never reorder.
- Buffer never overflows because of the occ bound; overflow is a simulation assertion.
- Flush (flush_=0): at the clock edge, clear all stage valids and empty the buffer; wb_req_=1 that cycle.
- Flush beats a simultaneous issue (dropped, no exe_start_) and a simultaneous ack (wb_e_=1 next cycle).
- A wb_e_ already asserted in the flush cycle still completes.
- Reset mid-operation discards everything immediately (async).
- Pointer wrap: buffer pointers are log2(DEPTH) bits wrapping modulo DEPTH; DEPTH must be a power of two; count is log2(DEPTH)+1 bits.

Optional Feature:
- Macro: MC_EXE_CTRL_STALL_CNT_EN.
- Defined: stall_cnt increments each cycle with wb_req_=0 and wb_ack_=1, saturating at 2^32-1; cleared by reset and flush_=0.
- Undefined: no counter logic; stall_cnt tied to 0.

Decomposition:
- exe.svh supplies the command typedef, ExpCode_t and `DivLatency/`FpuLatency defaults.
- decode.svh supplies RegFile_t.
- Add `MulLatency and the MC_EXE_CTRL depth defaults to cpu_config.svh.
- One natural sub-module: mc_exe_rbuf, the DEPTH-entry result FIFO with push/pop/count/head outputs.
- Latency tracker and writeback arbitration stay in mc_exe_ctrl.

Test Plan:
- Single op, LATENCY=4, issue rd=5 at cycle 10, wb_ack_ held 0 -> wb_req_=0 with pred_wb_rd=5 at cycle 14; wb_e_=0, wb_rd=5, wb_data=res at cycle 15 only.
- Pipelined back-to-back: DEPTH=4, issue every cycle rd=1..6, ack held 1 -> ops 1..4 accepted, busy_=0 from the 5th cycle. Then ack held 0 -> wb_rd order 1,2,3,4; busy_ returns 1 after the first pop.
- Iterative mode: PIPELINED=0, LATENCY=8, issue rd=3 then rd=4 next cycle -> busy_=0 for cycles t0+1..t0+8; rd=4 accepted at t0+9 at the earliest.
- Flush mid-flight: two ops in pipeline, one buffered, flush_=0 together with issue_=0 and wb_ack_=0 -> no exe_start_, no wb_e_ next cycle, occ=0, later results ignored.
- Exception pass-through: res_exp_=0, res_exp_code=nonzero code at arrival, acked the same cycle -> next cycle wb_exp_=0 with the same code, and the bypass path is taken (buffer stays empty).
- With MC_EXE_CTRL_STALL_CNT_EN: request held 7 cycles unacked -> stall_cnt=7; then flush -> stall_cnt=0.
